// File: rtl/io_hub_if.sv
// io_hub_if: cpu I/O port and peripheral channel bundle for io_hub.
//   slave  modport : hub side (cpu strobes/address/data in, d_out/interrupt and
//                    channel strobes out, channel read data and irqs in)
//   master modport : cpu/peripheral side, directions mirrored
interface io_hub_if #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned N_CH    = 4,
   parameter int unsigned CH_SPAN = 4
);
   localparam int unsigned AW = $clog2(CH_SPAN);

   logic                   read;
   logic                   write;
   logic                   push;
   logic                   push_ints;
   logic                   store_retaddr;
   logic                   push_retaddr;
   logic                   push_int_addr;
   logic [DATA_W-1:0]      d_addr;
   logic [DATA_W-1:0]      d_in;
   logic [DATA_W-1:0]      d_out;
   logic                   d_oe;
   logic                   interrupt;
   logic [N_CH-1:0]        ch_sel;
   logic                   ch_wr;
   logic                   ch_rd;
   logic [AW-1:0]          ch_addr;
   logic [DATA_W-1:0]      ch_wdata;
   logic [N_CH*DATA_W-1:0] ch_rdata;
   logic [N_CH-1:0]        ch_irq;

   modport slave (
      input  read, write, push, push_ints, store_retaddr, push_retaddr,
             push_int_addr, d_addr, d_in, ch_rdata, ch_irq,
      output d_out, d_oe, interrupt, ch_sel, ch_wr, ch_rd, ch_addr, ch_wdata
   );

   modport master (
      output read, write, push, push_ints, store_retaddr, push_retaddr,
             push_int_addr, d_addr, d_in, ch_rdata, ch_irq,
      input  d_out, d_oe, interrupt, ch_sel, ch_wr, ch_rd, ch_addr, ch_wdata
   );
endinterface

// File: rtl/io_hub.sv
// io_hub: N-channel memory-mapped I/O decoder with interrupt controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : io_hub_if.slave (cpu strobes, d_addr/d_in/d_out/d_oe, interrupt,
//              channel ch_sel/ch_wr/ch_rd/ch_addr/ch_wdata/ch_rdata/ch_irq)
// Optional macro IRQ_EDGE_EN: edge-triggered pending bits cleared on acknowledge;
// when undefined, pending follows the registered ch_irq level.
module io_hub #(
   parameter int unsigned       DATA_W     = 16,
   parameter int unsigned       N_CH       = 4,
   parameter int unsigned       CH_SPAN    = 4,
   parameter logic [DATA_W-1:0] IO_BASE    = 'hFF00,
   parameter logic [DATA_W-1:0] VEC_BASE   = 'h0010,
   parameter int unsigned       VEC_STRIDE = 4
) (
   input logic     clk,
   input logic     rst,
   io_hub_if.slave bus
);
   localparam int unsigned AW     = $clog2(CH_SPAN);
   localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned SLOT_W = DATA_W - AW;

   typedef enum logic [0:0] {S_IDLE, S_SERVICE} state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] r_retaddr;
   logic [N_CH-1:0]   r_mask;
   logic [N_CH-1:0]   r_irq_q;
   logic [IDX_W-1:0]  r_svc_idx;

   logic [DATA_W-1:0] w_offs;
   logic [SLOT_W-1:0] w_slot;
   logic [AW-1:0]     w_reg_off;
   logic              w_in_win;
   logic              w_ch_hit;
   logic              w_ctl_hit;
   logic [N_CH-1:0]   w_hit;
   logic [DATA_W-1:0] w_ch_data;
   logic [DATA_W-1:0] w_rd_val;
   logic              w_rd;
   logic              w_wr;
   logic [N_CH-1:0]   w_pend;
   logic [N_CH-1:0]   w_req;
   logic [IDX_W-1:0]  w_lowest;
   logic              w_ack;
   logic [DATA_W-1:0] w_vec;

   // Address decode relative to the I/O window
   assign w_offs    = bus.d_addr - IO_BASE;
   assign w_slot    = w_offs[DATA_W-1:AW];
   assign w_reg_off = w_offs[AW-1:0];
   assign w_in_win  = (bus.d_addr >= IO_BASE) &&
                      (w_offs < DATA_W'((N_CH + 1) * CH_SPAN));
   assign w_ch_hit  = w_in_win && (w_slot < SLOT_W'(N_CH));
   assign w_ctl_hit = w_in_win && (w_slot == SLOT_W'(N_CH));

   // Per-channel hit and read-data select
   always_comb begin
      w_hit     = '0;
      w_ch_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (w_ch_hit && (w_slot == SLOT_W'(k))) begin
            w_hit[k]  = 1'b1;
            w_ch_data = bus.ch_rdata[k*DATA_W +: DATA_W];
         end
      end
   end

   // Read wins over a simultaneous write
   assign w_rd = bus.read & ~rst;
   assign w_wr = bus.write & ~bus.read & ~rst;

   assign bus.ch_sel   = w_hit & {N_CH{w_rd | w_wr}};
   assign bus.ch_wr    = w_wr & w_ch_hit;
   assign bus.ch_rd    = w_rd & w_ch_hit;
   assign bus.ch_addr  = w_reg_off;
   assign bus.ch_wdata = bus.d_in;

   // Value captured on a read cycle
   always_comb begin
      w_rd_val = '0;
      if (w_ch_hit) begin
         w_rd_val = w_ch_data;
      end else if (w_ctl_hit) begin
         if (w_reg_off == AW'(0))      w_rd_val = DATA_W'(r_mask);
         else if (w_reg_off == AW'(1)) w_rd_val = DATA_W'(w_pend);
      end
   end

   assign w_req = w_pend & r_mask;

   // Lowest set request index wins
   always_comb begin
      w_lowest = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (w_req[k]) w_lowest = IDX_W'(k);
      end
   end

   assign w_ack = (r_state == S_IDLE) && bus.store_retaddr && (|w_req);
   assign w_vec = VEC_BASE + DATA_W'(r_svc_idx) * DATA_W'(VEC_STRIDE);

   assign bus.interrupt = (r_state == S_IDLE) && (|w_req);

   // cpu return path, fixed priority
   always_comb begin
      bus.d_oe  = bus.push_retaddr | bus.push_int_addr | bus.push_ints | bus.push;
      bus.d_out = '0;
      if (bus.push_retaddr)       bus.d_out = r_retaddr;
      else if (bus.push_int_addr) bus.d_out = w_vec;
      else if (bus.push_ints)     bus.d_out = DATA_W'(w_req);
      else if (bus.push)          bus.d_out = r_rdata;
   end

`ifdef IRQ_EDGE_EN
   logic [N_CH-1:0] r_irq_d;
   logic [N_CH-1:0] r_pend;
   logic [N_CH-1:0] w_clr;

   assign w_clr  = w_ack ? (N_CH'(1) << w_lowest) : '0;
   assign w_pend = r_pend;

   // Rising edge of registered irq sets; acknowledge clears; set wins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_irq_d <= '0;
         r_pend  <= '0;
      end else begin
         r_irq_d <= r_irq_q;
         r_pend  <= (r_pend & ~w_clr) | (r_irq_q & ~r_irq_d);
      end
   end
`else
   assign w_pend = r_irq_q;
`endif

   // Registers and interrupt service FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_rdata   <= '0;
         r_retaddr <= '0;
         r_mask    <= '0;
         r_irq_q   <= '0;
         r_svc_idx <= '0;
      end else begin
         r_irq_q <= bus.ch_irq;
         if (bus.read) r_rdata <= w_rd_val;
         if (w_wr && w_ctl_hit && (w_reg_off == AW'(0))) r_mask <= bus.d_in[N_CH-1:0];
         case (r_state)
            S_IDLE: begin
               if (w_ack) begin
                  r_retaddr <= bus.d_in;
                  r_svc_idx <= w_lowest;
                  r_state   <= S_SERVICE;
               end
            end
            S_SERVICE: begin
               if (bus.push_retaddr) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
